// File: rtl/surface_vec_scheduler_pkg.sv
// Shared vector package for the surface-vector scheduler.
//   fp_t / vec3_t     : Q8.24 fixed point scalar and 3-component vector
//   FP_* / VEC3_ZERO  : Q8.24 constants
//   sched_state_e     : scheduler FSM states
//   lane_idx_t        : ray-march lane index carried in the tag FIFO
//   sv_issue_t        : payload sent to the surface-vector pipeline
//   sv_result_t       : payload returned by the pipeline, forwarded to lanes
package surface_vec_scheduler_pkg;

    localparam int FP_W    = 32;
    localparam int FP_FRAC = 24;

    typedef logic signed [FP_W-1:0] fp_t;

    typedef struct packed {
        fp_t x;
        fp_t y;
        fp_t z;
    } vec3_t;

    localparam fp_t   FP_ZERO   = 32'sh0000_0000;
    localparam fp_t   FP_ONE    = 32'sh0100_0000;
    localparam vec3_t VEC3_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } sched_state_e;

    // Wide enough for up to 16 lanes; tags are narrowed nowhere else.
    localparam int LANE_W = 4;
    typedef logic [LANE_W-1:0] lane_idx_t;

    typedef struct packed {
        logic  hit;
        vec3_t p;
    } sv_issue_t;

    typedef struct packed {
        logic  hit;
        vec3_t normal;
        vec3_t light;
    } sv_result_t;

endpackage

// File: rtl/surface_vec_scheduler_tag_fifo.sv
// tag_fifo: synchronous FIFO holding the owning-lane tag of every request
// outstanding in the surface-vector pipeline.
//   clk, rst      : clock, async active-low reset (empties the FIFO)
//   push/push_data: enqueue (ignored when full)
//   pop           : dequeue (ignored when empty)
//   head          : current head entry (valid only when !empty)
//   full/empty    : occupancy flags
// DEPTH must be a power of two (>= 2): pointers carry one extra wrap bit so
// full and empty are distinguished without a separate counter.
module tag_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is not reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/surface_vec_scheduler.sv
// surface_vec_scheduler: arbitrates N_REQ ray-march lanes onto a single
// in-order surface-vector pipeline and routes results back to their owners.
//   clk, rst                     : clock, async active-low reset
//   req_valid/req_ready          : per-lane request handshake (ready one-hot)
//   req_p/req_hit                : per-lane hit point (Q8.24 vec3) and hit flag
//   obj_sel                      : requested scene; a change drains the pipe
//   sv_valid_in/sv_p/sv_hit      : registered issue bus to the pipeline
//   sv_obj_sel                   : scene select in force (latched copy)
//   sv_valid_out/sv_normal/...   : pipeline result bus, in order, no stall
//   rsp_valid                    : one-hot result strobe to owning lane
//   rsp_normal/rsp_light/rsp_hit : registered result payload, shared
//   inflight                     : outstanding request count
//   busy                         : work outstanding or scene switch pending
//   err_orphan                   : sticky, result arrived with no owner
module surface_vec_scheduler
    import surface_vec_scheduler_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  vec3_t [N_REQ-1:0]             req_p,
    input  logic [N_REQ-1:0]              req_hit,
    input  logic                          obj_sel,
    output logic                          sv_valid_in,
    output vec3_t                         sv_p,
    output logic                          sv_hit,
    output logic                          sv_obj_sel,
    input  logic                          sv_valid_out,
    input  vec3_t                         sv_normal,
    input  vec3_t                         sv_light,
    input  logic                          sv_hit_out,
    output logic [N_REQ-1:0]              rsp_valid,
    output vec3_t                         rsp_normal,
    output vec3_t                         rsp_light,
    output logic                          rsp_hit,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          busy,
    output logic                          err_orphan
);

    localparam int CNT_W = $clog2(MAX_INFLIGHT) + 1;

    sched_state_e     state;
    sched_state_e     state_nxt;
    logic             obj_lat;
    logic             obj_load;

    lane_idx_t        rr_ptr;
    lane_idx_t        hi_idx;
    lane_idx_t        lo_idx;
    lane_idx_t        gnt_idx;
    logic             hi_any;
    logic             lo_any;
    logic             can_issue;
    logic             hs;
    logic [N_REQ-1:0] gnt_oh;
    sv_issue_t        issue_sel;
    sv_issue_t        issue_q;
    logic             issue_vld_q;

    logic             pop;
    logic             orphan;
    lane_idx_t        tag_head;
    logic             tag_full;
    logic             tag_empty;
    logic [CNT_W-1:0] cnt_q;

    logic [N_REQ-1:0] rsp_vld_nxt;
    logic [N_REQ-1:0] rsp_vld_q;
    sv_result_t       rsp_q;
    logic             err_q;

    // ---------------------------------------------------------------- issue
    // rst gates issue so req_ready is low for the whole reset window. The
    // FIFO full flag is equivalent to the counter limit; both are kept so
    // neither structure can be overrun if the other is disturbed.
    assign can_issue = rst && (state == ST_RUN)
                    && (cnt_q < CNT_W'(MAX_INFLIGHT)) && !tag_full;

    // Round robin as two priority searches: lowest requester at or above
    // rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        hi_any = 1'b0;
        lo_any = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_any = 1'b1;
                lo_idx = lane_idx_t'(i);
                if (lane_idx_t'(i) >= rr_ptr) begin
                    hi_any = 1'b1;
                    hi_idx = lane_idx_t'(i);
                end
            end
        end
    end

    assign gnt_idx = hi_any ? hi_idx : lo_idx;
    assign hs      = can_issue && lo_any;

    always_comb begin
        gnt_oh    = '0;
        issue_sel = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_idx == lane_idx_t'(i)) begin
                gnt_oh[i]     = hs;
                issue_sel.p   = req_p[i];
                issue_sel.hit = req_hit[i];
            end
        end
    end

    assign req_ready = gnt_oh;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr      <= '0;
            issue_vld_q <= 1'b0;
            issue_q     <= '0;
        end else begin
            issue_vld_q <= hs;
            issue_q     <= hs ? issue_sel : '0;
            if (hs) rr_ptr <= (gnt_idx == lane_idx_t'(N_REQ - 1)) ? '0
                                                                  : gnt_idx + lane_idx_t'(1);
        end
    end

    assign sv_valid_in = issue_vld_q;
    assign sv_p        = issue_q.p;
    assign sv_hit      = issue_q.hit;
    assign sv_obj_sel  = obj_lat;

    // ------------------------------------------------------------- tracking
    assign pop    = sv_valid_out && !tag_empty;
    assign orphan = sv_valid_out && tag_empty;

    tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (LANE_W)
    ) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (hs),
        .push_data (gnt_idx),
        .pop       (pop),
        .head      (tag_head),
        .full      (tag_full),
        .empty     (tag_empty)
    );

    // Issue and retire in the same cycle cancel out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (hs && !pop) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !hs) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign inflight = cnt_q;

    // ------------------------------------------------------------- response
    always_comb begin
        rsp_vld_nxt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_vld_nxt[i] = pop && (tag_head == lane_idx_t'(i));
        end
    end

    // Payload only loads on a tagged result; orphans leave it untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_vld_q <= '0;
            rsp_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            rsp_vld_q <= rsp_vld_nxt;
            if (pop) begin
                rsp_q.hit    <= sv_hit_out;
                rsp_q.normal <= sv_normal;
                rsp_q.light  <= sv_light;
            end
            if (orphan) err_q <= 1'b1;
        end
    end

    assign rsp_valid  = rsp_vld_q;
    assign rsp_normal = rsp_q.normal;
    assign rsp_light  = rsp_q.light;
    assign rsp_hit    = rsp_q.hit;
    assign err_orphan = err_q;

    // ------------------------------------------------------- scene switch
    // DRAIN looks at the registered count, so the cycle of the final pop
    // still reads nonzero and SWITCH follows one cycle later. obj_sel is
    // sampled again only in SWITCH, so toggling back mid-drain is harmless.
    always_comb begin
        state_nxt = state;
        obj_load  = 1'b0;
        case (state)
            ST_RUN:    if (obj_sel != obj_lat) state_nxt = ST_DRAIN;
            ST_DRAIN:  if (cnt_q == '0)        state_nxt = ST_SWITCH;
            ST_SWITCH: begin
                obj_load  = 1'b1;
                state_nxt = ST_RUN;
            end
            default:   state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_RUN;
            obj_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (obj_load) obj_lat <= obj_sel;
        end
    end

    assign busy = (cnt_q != '0) || (state != ST_RUN);

endmodule

// File: tb/tb_surface_vec_scheduler.sv
module tb_surface_vec_scheduler;
    import surface_vec_scheduler_pkg::*;

    localparam int N  = 4;
    localparam int MI = 8;
    localparam int IW = $clog2(MI) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_ready, req_hit, rsp_valid;
    vec3_t [N-1:0]  req_p;
    logic           obj_sel, sv_valid_in, sv_hit, sv_obj_sel;
    logic           sv_valid_out, sv_hit_out, rsp_hit, busy, err_orphan;
    vec3_t          sv_p, sv_normal, sv_light, rsp_normal, rsp_light;
    logic [IW-1:0]  inflight;

    always #5 clk = ~clk;

    surface_vec_scheduler #(.N_REQ(N), .MAX_INFLIGHT(MI)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_p(req_p), .req_hit(req_hit),
        .obj_sel(obj_sel),
        .sv_valid_in(sv_valid_in), .sv_p(sv_p), .sv_hit(sv_hit), .sv_obj_sel(sv_obj_sel),
        .sv_valid_out(sv_valid_out), .sv_normal(sv_normal), .sv_light(sv_light),
        .sv_hit_out(sv_hit_out),
        .rsp_valid(rsp_valid), .rsp_normal(rsp_normal), .rsp_light(rsp_light), .rsp_hit(rsp_hit),
        .inflight(inflight), .busy(busy), .err_orphan(err_orphan)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------------------------------------------- reference model
    // Outstanding owners kept as a plain queue; scene mode 0=run 1=drain 2=switch.
    int           m_q[$];
    int           m_rr, m_st;
    logic         m_lat, m_svv, m_svh, m_rsph, m_err;
    vec3_t        m_svp, m_rspn, m_rspl;
    logic [N-1:0] m_rspv;

    function automatic void m_reset();
        m_q.delete();
        m_rr = 0; m_st = 0; m_lat = 1'b0;
        m_svv = 1'b0; m_svp = '0; m_svh = 1'b0;
        m_rspv = '0; m_rspn = '0; m_rspl = '0; m_rsph = 1'b0; m_err = 1'b0;
    endfunction

    function automatic logic [N-1:0] m_grant();
        logic [N-1:0] sh;
        if (rst !== 1'b1 || m_st != 0 || m_q.size() >= MI) return '0;
        for (int k = 0; k < N; k++) begin
            sh = req_valid >> ((m_rr + k) % N);
            if (sh[0]) return N'(1) << ((m_rr + k) % N);
        end
        return '0;
    endfunction

    task automatic m_check();
        chk("req_ready",   128'(req_ready),   128'(m_grant()));
        chk("sv_valid_in", 128'(sv_valid_in), 128'(m_svv));
        chk("sv_p",        128'(sv_p),        128'(m_svp));
        chk("sv_hit",      128'(sv_hit),      128'(m_svh));
        chk("sv_obj_sel",  128'(sv_obj_sel),  128'(m_lat));
        chk("rsp_valid",   128'(rsp_valid),   128'(m_rspv));
        chk("rsp_normal",  128'(rsp_normal),  128'(m_rspn));
        chk("rsp_light",   128'(rsp_light),   128'(m_rspl));
        chk("rsp_hit",     128'(rsp_hit),     128'(m_rsph));
        chk("inflight",    128'(inflight),    128'(m_q.size()));
        chk("busy",        128'(busy),        128'(m_q.size() != 0 || m_st != 0));
        chk("err_orphan",  128'(err_orphan),  128'(m_err));
    endtask

    task automatic m_step();
        logic [N-1:0] g;
        int lane, pre, l;
        vec3_t p;
        logic h;
        if (rst !== 1'b1) begin
            m_reset();
            return;
        end
        g = m_grant();
        lane = -1; p = '0; h = 1'b0;
        for (int i = 0; i < N; i++) if (g[i]) begin lane = i; p = req_p[i]; h = req_hit[i]; end
        pre = m_q.size();
        case (m_st)
            0:       if (obj_sel != m_lat) m_st = 1;
            1:       if (pre == 0) m_st = 2;
            default: begin m_lat = obj_sel; m_st = 0; end
        endcase
        m_svv = (lane >= 0); m_svp = p; m_svh = h;
        m_rspv = '0;
        if (sv_valid_out) begin
            if (pre > 0) begin
                l = m_q.pop_front();
                m_rspv = N'(1) << l;
                m_rspn = sv_normal; m_rspl = sv_light; m_rsph = sv_hit_out;
            end else begin
                m_err = 1'b1;
            end
        end
        if (lane >= 0) begin
            m_q.push_back(lane);
            m_rr = (lane + 1) % N;
        end
    endtask

    // Inputs change at posedge+1; outputs are compared at negedge.
    task automatic to_neg(); @(negedge clk); m_check(); endtask
    task automatic to_pos(); @(posedge clk); m_step(); #1; endtask
    task automatic cyc();    to_neg(); to_pos(); endtask

    function automatic vec3_t rvec();
        return vec3_t'({$urandom, $urandom, $urandom});
    endfunction

    task automatic rand_payload();
        for (int i = 0; i < N; i++) begin req_p[i] = rvec(); req_hit[i] = 1'($urandom); end
        sv_normal = rvec(); sv_light = rvec(); sv_hit_out = 1'($urandom);
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Requests held high during reset must not be granted.
    task automatic do_reset();
        req_valid = '1; sv_valid_out = 1'b0; obj_sel = 1'b0;
        rst = 1'b0; m_reset();
        repeat (2) cyc();
        req_valid = '0;
        rst = 1'b1;
    endtask

    typedef struct {
        logic [N-1:0] rv;
        logic         svo;
        logic [N-1:0] rdy;
        int           infl;
        logic [N-1:0] rspv;
    } vec_t;

    vec_t tbl[10];
    int   gq[$];
    int   rq[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, idle, nrsp, svo_pct;
        logic got;
        logic [15:0] pipe;

        // {req_valid, sv_valid_out, req_ready, inflight, rsp_valid} per cycle from reset
        tbl[0] = '{4'b1010, 1'b0, 4'b0010, 0, 4'b0000};
        tbl[1] = '{4'b1010, 1'b0, 4'b1000, 1, 4'b0000};
        tbl[2] = '{4'b0001, 1'b0, 4'b0001, 2, 4'b0000};
        tbl[3] = '{4'b0001, 1'b1, 4'b0001, 3, 4'b0000};
        tbl[4] = '{4'b0110, 1'b1, 4'b0010, 3, 4'b0010};
        tbl[5] = '{4'b0000, 1'b1, 4'b0000, 3, 4'b1000};
        tbl[6] = '{4'b1111, 1'b0, 4'b0100, 2, 4'b0001};
        tbl[7] = '{4'b1111, 1'b0, 4'b1000, 3, 4'b0000};
        tbl[8] = '{4'b0000, 1'b1, 4'b0000, 4, 4'b0000};
        tbl[9] = '{4'b0000, 1'b0, 4'b0000, 3, 4'b0001};

        rst = 1'b0; req_valid = '0; req_p = '0; req_hit = '0; obj_sel = 1'b0;
        sv_valid_out = 1'b0; sv_normal = '0; sv_light = '0; sv_hit_out = 1'b0;
        m_reset();

        // Table-driven arbitration / counting from reset
        do_reset();
        for (int k = 0; k < 10; k++) begin
            req_valid = tbl[k].rv; sv_valid_out = tbl[k].svo; rand_payload();
            to_neg();
            chk($sformatf("tbl%0d_ready", k),    128'(req_ready), 128'(tbl[k].rdy));
            chk($sformatf("tbl%0d_inflight", k), 128'(inflight),  128'(tbl[k].infl));
            chk($sformatf("tbl%0d_rsp", k),      128'(rsp_valid), 128'(tbl[k].rspv));
            to_pos();
        end

        // Lanes 0 and 2 continuously, pipeline latency 10
        do_reset();
        gq.delete(); rq.delete(); pipe = '0;
        for (int c = 0; c < 60; c++) begin
            req_valid = (c < 40) ? 4'b0101 : 4'b0000;
            sv_valid_out = pipe[9]; rand_payload();
            to_neg();
            if (req_ready != '0) gq.push_back(oh_idx(req_ready));
            if (rsp_valid != '0) rq.push_back(oh_idx(rsp_valid));
            pipe = {pipe[14:0], sv_valid_in};
            to_pos();
        end
        chk("alt_issue_count_ge8", 128'(gq.size() >= 8), 128'(1));
        chk("alt_rsp_count",       128'(rq.size()),      128'(gq.size()));
        for (int k = 0; k < 8 && k < gq.size() && k < rq.size(); k++) begin
            chk($sformatf("alt_issue%0d", k), 128'(gq[k]), 128'((k % 2) * 2));
            chk($sformatf("alt_rsp%0d", k),   128'(rq[k]), 128'((k % 2) * 2));
        end

        // All lanes, pipeline stalled: exactly MAX_INFLIGHT handshakes
        do_reset();
        req_valid = '1; cnt = 0;
        for (int c = 0; c < 12; c++) begin
            rand_payload(); to_neg();
            if (req_ready != '0) cnt++;
            to_pos();
        end
        chk("full_handshakes", 128'(cnt), 128'(8));
        sv_valid_out = 1'b1;
        to_neg();
        chk("full_inflight", 128'(inflight), 128'(8));
        chk("full_ready",    128'(req_ready), 128'(0));
        to_pos();
        sv_valid_out = 1'b0;
        to_neg();
        chk("full_regrant",   128'(req_ready), 128'(4'b0001));
        chk("full_first_rsp", 128'(rsp_valid), 128'(4'b0001));
        to_pos();

        // Issue and retire in the same cycle at inflight=5
        do_reset();
        req_valid = '1;
        repeat (5) cyc();
        sv_valid_out = 1'b1;
        to_neg();
        chk("same_pre_inflight", 128'(inflight),  128'(5));
        chk("same_grant",        128'(req_ready), 128'(4'b0010));
        to_pos();
        sv_valid_out = 1'b0; req_valid = '0;
        to_neg();
        chk("same_post_inflight", 128'(inflight), 128'(5));
        to_pos();

        // Scene switch with three outstanding
        do_reset();
        req_valid = 4'b0001;
        repeat (3) cyc();
        req_valid = '0; obj_sel = 1'b1;
        cyc();
        req_valid = '1; idle = 0; nrsp = 0; got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            sv_valid_out = (c < 3); rand_payload();
            to_neg();
            if (rsp_valid != '0) nrsp++;
            if (c == 4) begin
                chk("switch_busy",     128'(busy),     128'(1));
                chk("switch_inflight", 128'(inflight), 128'(0));
            end
            if (req_ready != '0) begin
                got = 1'b1;
                chk("switch_obj_sel", 128'(sv_obj_sel), 128'(1));
                chk("switch_resume",  128'(req_ready),  128'(4'b0010));
            end else begin
                idle++;
            end
            to_pos();
        end
        chk("switch_resumed",  128'(got),  128'(1));
        chk("switch_idle_cyc", 128'(idle), 128'(5));
        chk("switch_results",  128'(nrsp), 128'(3));
        req_valid = '0; sv_valid_out = 1'b0;

        // Result with nothing issued
        do_reset();
        to_neg();
        chk("orphan_pre_err", 128'(err_orphan), 128'(0));
        to_pos();
        sv_valid_out = 1'b1;
        cyc();
        sv_valid_out = 1'b0;
        to_neg();
        chk("orphan_err",      128'(err_orphan), 128'(1));
        chk("orphan_rsp",      128'(rsp_valid),  128'(0));
        chk("orphan_inflight", 128'(inflight),   128'(0));
        to_pos();

        // Reset with four outstanding, then stale results arrive
        do_reset();
        req_valid = '1;
        repeat (4) cyc();
        rst = 1'b0; m_reset();
        #1;
        chk("rst_async_inflight", 128'(inflight),    128'(0));
        chk("rst_async_svv",      128'(sv_valid_in), 128'(0));
        chk("rst_async_ready",    128'(req_ready),   128'(0));
        chk("rst_async_busy",     128'(busy),        128'(0));
        repeat (2) cyc();
        req_valid = '0; rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            sv_valid_out = 1'b1; rand_payload();
            to_neg();
            if (k > 0) chk($sformatf("rst_stale%0d_err", k), 128'(err_orphan), 128'(1));
            chk($sformatf("rst_stale%0d_rsp", k), 128'(rsp_valid), 128'(0));
            to_pos();
        end
        sv_valid_out = 1'b0;
        to_neg();
        chk("rst_stale_err",     128'(err_orphan), 128'(1));
        chk("rst_stale_payload", 128'(rsp_normal), 128'(0));
        chk("rst_stale_infl",    128'(inflight),   128'(0));
        to_pos();

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom);
            rand_payload();
            if ($urandom_range(0, 99) < 3) obj_sel = ~obj_sel;
            svo_pct = ((c / 500) % 2 == 1) ? 70 : 25;
            sv_valid_out = (m_q.size() > 0) && ($urandom_range(0, 99) < svo_pct);
            if (m_q.size() == 0 && $urandom_range(0, 399) == 0) sv_valid_out = 1'b1;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
